// File: rtl/imm_encoder_pkg.sv
// Shared types for the immediate encoder: format selector, instruction width
// and a sign-extension fit helper used by the optional range check.
package imm_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        FMT_I       = 3'd0,
        FMT_S       = 3'd1,
        FMT_B       = 3'd2,
        FMT_U       = 3'd3,
        FMT_J       = 3'd4,
        FMT_SHAMT   = 3'd5,
        FMT_ZIMM    = 3'd6,
        FMT_ILLEGAL = 3'd7
    } imm_fmt_t;

    // True when v[63:lo] are all equal, i.e. v is a sign extension of v[lo:0].
    function automatic logic sext_fits(input logic [63:0] v, input int lo);
        logic [63:0] sh;
        sh = 64'($signed(v) >>> lo);
        return (sh == '0) || (&sh);
    endfunction

endpackage

// File: rtl/imm_encoder_skid.sv
// Generic 2-entry valid/ready buffer. Entry 0 is always the head; a pop with
// two entries shifts entry 1 forward. in_ready depends only on occupancy.
module imm_encoder_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] e0, e1;
    logic [1:0]   cnt;
    logic         push, pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = e0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        e0  <= in_data;
                        cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0 <= in_data;
                    end else if (push) begin
                        e1  <= in_data;
                        cnt <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push is possible, only a drain into the head.
                    if (pop) begin
                        e0  <= e1;
                        cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs format/fields/immediate into an RV instruction word behind a 2-entry
// skid buffer. Define IMM_RANGE_CHECK_EN to flag immediates that do not fit.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [63:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    imm_fmt_t           fmt;
    logic [INSTR_W-1:0] enc;
    logic               bad_fmt;
    logic               range_err;
    logic               err;
    logic               accept;
    logic               unused_bits;

    assign fmt = imm_fmt_t'(in_fmt);

    always_comb begin
        enc     = '0;
        bad_fmt = 1'b0;
        case (fmt)
            FMT_I:     enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S:     enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B:     enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            FMT_U:     enc = {in_imm[31:12], in_rd, in_opcode};
            FMT_J:     enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            FMT_SHAMT: enc = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_ZIMM:  enc = {in_imm[31:20], in_imm[4:0], in_funct3, in_rd, in_opcode};
            default:   bad_fmt = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = !sext_fits(in_imm, 11);
            FMT_B:        range_err = !sext_fits(in_imm, 12) || in_imm[0];
            FMT_J:        range_err = !sext_fits(in_imm, 20) || in_imm[0];
            FMT_U:        range_err = (|in_imm[11:0]) || !sext_fits(in_imm, 31);
            FMT_SHAMT:    range_err = |in_imm[63:6];
            FMT_ZIMM:     range_err = (|in_imm[63:32]) || (|in_imm[19:5]);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Bits that only the range check or nothing at all looks at.
    assign unused_bits = ^{in_imm[63:32], in_funct7[0]};

    assign err    = bad_fmt || range_err;
    assign accept = in_valid && in_ready;

    imm_encoder_skid #(.W(INSTR_W + 1)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({enc, err}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_instr, out_err})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && err && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
